// File: rtl/cond_pkg.sv
// Shared definitions for the conditional-execution unit: ARM condition codes
// and NZCV bit positions within a flag word.
package cond_pkg;

  typedef enum logic [3:0] {
    EQ = 4'b0000, NE = 4'b0001, CS = 4'b0010, CC = 4'b0011,
    MI = 4'b0100, PL = 4'b0101, VS = 4'b0110, VC = 4'b0111,
    HI = 4'b1000, LS = 4'b1001, GE = 4'b1010, LT = 4'b1011,
    GT = 4'b1100, LE = 4'b1101, AL = 4'b1110, NV = 4'b1111
  } cond_t;

  localparam int N_BIT = 3;
  localparam int Z_BIT = 2;
  localparam int C_BIT = 1;
  localparam int V_BIT = 0;

endpackage

// File: rtl/cond_unit_pipe_if.sv
// Bundle of the execute-stage signals around cond_unit_pipe; the master side
// drives the decoder/ALU inputs, the slave side is the conditional unit.
interface cond_unit_pipe_if #(
  parameter int BANK_W = 1
);
  logic              valid_in;
  logic              stall;
  logic              flush;
  logic [BANK_W-1:0] bank_sel;
  logic [3:0]        cond;
  logic [3:0]        alu_flags;
  logic [1:0]        flag_w;
  logic              pcs;
  logic              reg_w;
  logic              mem_w;
  logic              pc_src;
  logic              reg_write;
  logic              mem_write;
  logic              cond_ex;
  logic              valid_out;
  logic [3:0]        flags_out;
  logic              carry_out;

  // Handshake: an instruction is accepted on a rising edge when valid_in=1,
  // stall=0 and flush=0; stall holds it in place, flush discards it.
  modport master (
    output valid_in, stall, flush, bank_sel, cond, alu_flags, flag_w,
           pcs, reg_w, mem_w,
    input  pc_src, reg_write, mem_write, cond_ex, valid_out, flags_out, carry_out
  );

  modport slave (
    input  valid_in, stall, flush, bank_sel, cond, alu_flags, flag_w,
           pcs, reg_w, mem_w,
    output pc_src, reg_write, mem_write, cond_ex, valid_out, flags_out, carry_out
  );
endinterface

// File: rtl/cond_eval.sv
// Pure combinational ARM condition-code evaluation against one NZCV word.
module cond_eval
  import cond_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] flags,
  output logic       cond_ex
);

  logic n, z, c, v;

  assign n = flags[N_BIT];
  assign z = flags[Z_BIT];
  assign c = flags[C_BIT];
  assign v = flags[V_BIT];

  always_comb begin
    cond_ex = 1'b0;
    case (cond_t'(cond))
      EQ: cond_ex = z;
      NE: cond_ex = ~z;
      CS: cond_ex = c;
      CC: cond_ex = ~c;
      MI: cond_ex = n;
      PL: cond_ex = ~n;
      VS: cond_ex = v;
      VC: cond_ex = ~v;
      HI: cond_ex = c & ~z;
      LS: cond_ex = ~c | z;
      GE: cond_ex = (n == v);
      LT: cond_ex = (n != v);
      GT: cond_ex = ~z & (n == v);
      LE: cond_ex = z | (n != v);
      AL: cond_ex = 1'b1;
      NV: cond_ex = 1'b0;
      default: cond_ex = 1'b0;
    endcase
  end

endmodule

// File: rtl/cond_unit_pipe.sv
// Execute-stage conditional unit: banked NZCV flags, condition evaluation and
// gating of the decoder's write requests, with optional output registers.
module cond_unit_pipe
  import cond_pkg::*;
#(
  parameter int NUM_BANKS = 2,
  parameter bit REG_OUT   = 1'b1,
  localparam int BANK_W   = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic              stall,
  input  logic              flush,
  input  logic [BANK_W-1:0] bank_sel,
  input  logic [3:0]        cond,
  input  logic [3:0]        alu_flags,
  input  logic [1:0]        flag_w,
  input  logic              pcs,
  input  logic              reg_w,
  input  logic              mem_w,
  output logic              pc_src,
  output logic              reg_write,
  output logic              mem_write,
  output logic              cond_ex,
  output logic              valid_out,
  output logic [3:0]        flags_out,
  output logic              carry_out
);

  logic [3:0] banks [NUM_BANKS];
  logic [3:0] sel_flags;
  logic       bank_ok;
  logic       eval_ex;
  logic       issue;
  logic       we_pc, we_reg, we_mem;

  assign bank_ok = (32'(bank_sel) < NUM_BANKS);

  // An out-of-range bank reads as zero; cond_ex is gated separately below.
  always_comb begin
    sel_flags = 4'b0000;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (bank_sel == BANK_W'(i)) sel_flags = banks[i];
    end
  end

  cond_eval u_eval (
    .cond    (cond),
    .flags   (sel_flags),
    .cond_ex (eval_ex)
  );

  assign cond_ex   = bank_ok & eval_ex;
  assign issue     = valid_in & ~stall & ~flush & bank_ok;
  assign flags_out = sel_flags;
  assign carry_out = sel_flags[C_BIT];

  assign we_pc  = pcs   & cond_ex & issue;
  assign we_reg = reg_w & cond_ex & issue;
  assign we_mem = mem_w & cond_ex & issue;

  // issue already excludes stall, so a stalled instruction writes only once,
  // on the edge where it finally leaves the stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_BANKS; i++) banks[i] <= 4'b0000;
    end else begin
      for (int i = 0; i < NUM_BANKS; i++) begin
        if (issue && cond_ex && (bank_sel == BANK_W'(i))) begin
          if (flag_w[1]) banks[i][3:2] <= alu_flags[3:2];
          if (flag_w[0]) banks[i][1:0] <= alu_flags[1:0];
        end
      end
    end
  end

  generate
    if (REG_OUT) begin : g_reg_out
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          pc_src    <= 1'b0;
          reg_write <= 1'b0;
          mem_write <= 1'b0;
          valid_out <= 1'b0;
        end else if (flush) begin
          pc_src    <= 1'b0;
          reg_write <= 1'b0;
          mem_write <= 1'b0;
          valid_out <= 1'b0;
        end else if (!stall) begin
          pc_src    <= we_pc;
          reg_write <= we_reg;
          mem_write <= we_mem;
          valid_out <= issue;
        end
      end
    end else begin : g_comb_out
      assign pc_src    = we_pc;
      assign reg_write = we_reg;
      assign mem_write = we_mem;
      assign valid_out = issue;
    end
  endgenerate

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Bench for cond_unit_pipe: one registered and one combinational instance
// (three banks each) driven in lockstep and compared to a flag-bank model.
module tb_cond_unit_pipe;

  localparam int NB = 3;
  localparam int BW = 2;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  // stimulus variables, fanned out to both interfaces
  logic          vi, st, fl, p, r, m;
  logic [BW-1:0] bs;
  logic [3:0]    cd, alu;
  logic [1:0]    fw;

  cond_unit_pipe_if #(.BANK_W(BW)) if_a ();
  cond_unit_pipe_if #(.BANK_W(BW)) if_b ();

  assign if_a.valid_in = vi;  assign if_b.valid_in = vi;
  assign if_a.stall = st;     assign if_b.stall = st;
  assign if_a.flush = fl;     assign if_b.flush = fl;
  assign if_a.bank_sel = bs;  assign if_b.bank_sel = bs;
  assign if_a.cond = cd;      assign if_b.cond = cd;
  assign if_a.alu_flags = alu; assign if_b.alu_flags = alu;
  assign if_a.flag_w = fw;    assign if_b.flag_w = fw;
  assign if_a.pcs = p;        assign if_b.pcs = p;
  assign if_a.reg_w = r;      assign if_b.reg_w = r;
  assign if_a.mem_w = m;      assign if_b.mem_w = m;

  cond_unit_pipe #(.NUM_BANKS(NB), .REG_OUT(1'b1)) dut_a (
    .clk(clk), .reset(reset), .valid_in(if_a.valid_in), .stall(if_a.stall),
    .flush(if_a.flush), .bank_sel(if_a.bank_sel), .cond(if_a.cond),
    .alu_flags(if_a.alu_flags), .flag_w(if_a.flag_w), .pcs(if_a.pcs),
    .reg_w(if_a.reg_w), .mem_w(if_a.mem_w), .pc_src(if_a.pc_src),
    .reg_write(if_a.reg_write), .mem_write(if_a.mem_write),
    .cond_ex(if_a.cond_ex), .valid_out(if_a.valid_out),
    .flags_out(if_a.flags_out), .carry_out(if_a.carry_out)
  );

  cond_unit_pipe #(.NUM_BANKS(NB), .REG_OUT(1'b0)) dut_b (
    .clk(clk), .reset(reset), .valid_in(if_b.valid_in), .stall(if_b.stall),
    .flush(if_b.flush), .bank_sel(if_b.bank_sel), .cond(if_b.cond),
    .alu_flags(if_b.alu_flags), .flag_w(if_b.flag_w), .pcs(if_b.pcs),
    .reg_w(if_b.reg_w), .mem_w(if_b.mem_w), .pc_src(if_b.pc_src),
    .reg_write(if_b.reg_write), .mem_write(if_b.mem_write),
    .cond_ex(if_b.cond_ex), .valid_out(if_b.valid_out),
    .flags_out(if_b.flags_out), .carry_out(if_b.carry_out)
  );

  // reference state: flag banks and the four registered outputs of dut_a
  logic [3:0] m_flags [NB];
  logic       m_pc, m_rw, m_mw, m_vo;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit ref_cond(input logic [3:0] c, input logic [3:0] f);
    bit n = f[3], z = f[2], cy = f[1], v = f[0];
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && (n == v);
      4'd13: return z || (n != v);
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic model_clear();
    for (int i = 0; i < NB; i++) m_flags[i] = 4'b0000;
    {m_pc, m_rw, m_mw, m_vo} = 4'b0000;
  endtask

  task automatic drive(input logic v_, st_, fl_, input logic [BW-1:0] bs_,
                       input logic [3:0] cd_, alu_, input logic [1:0] fw_,
                       input logic p_, r_, m_);
    vi = v_; st = st_; fl = fl_; bs = bs_; cd = cd_; alu = alu_; fw = fw_;
    p = p_; r = r_; m = m_;
  endtask

  // One clock: compare combinational results before the edge, advance the
  // model on the edge, then compare the registered outputs after it.
  task automatic tick();
    bit ok, ce, iss;
    logic [3:0] f;
    #1;
    ok  = (int'(bs) < NB);
    f   = ok ? m_flags[bs] : 4'b0000;
    ce  = ok && ref_cond(cd, f);
    iss = vi && !st && !fl && ok;
    check("cond_ex_a", 32'(if_a.cond_ex), 32'(ce));
    check("cond_ex_b", 32'(if_b.cond_ex), 32'(ce));
    if (ok) begin
      check("flags_out", 32'(if_a.flags_out), 32'(f));
      check("carry_out", 32'(if_a.carry_out), 32'(f[1]));
    end
    check("pc_src_b", 32'(if_b.pc_src), 32'(p && ce && iss));
    check("reg_write_b", 32'(if_b.reg_write), 32'(r && ce && iss));
    check("mem_write_b", 32'(if_b.mem_write), 32'(m && ce && iss));
    check("valid_out_b", 32'(if_b.valid_out), 32'(iss));
    @(posedge clk);
    if (iss && ce) begin
      if (fw[1]) m_flags[bs][3:2] = alu[3:2];
      if (fw[0]) m_flags[bs][1:0] = alu[1:0];
    end
    if (fl) {m_pc, m_rw, m_mw, m_vo} = 4'b0000;
    else if (!st) {m_pc, m_rw, m_mw, m_vo} = {p && ce && iss, r && ce && iss, m && ce && iss, iss};
    #1;
    check("pc_src_a", 32'(if_a.pc_src), 32'(m_pc));
    check("reg_write_a", 32'(if_a.reg_write), 32'(m_rw));
    check("mem_write_a", 32'(if_a.mem_write), 32'(m_mw));
    check("valid_out_a", 32'(if_a.valid_out), 32'(m_vo));
    @(negedge clk);
  endtask

  task automatic random_ticks(input int count);
    for (int k = 0; k < count; k++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0,
            $urandom_range(0, 7) == 0, BW'($urandom_range(0, 3)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      tick();
    end
  endtask

  initial begin
    model_clear();
    drive(0, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 0, 0);
    repeat (2) @(negedge clk);
    check("rst_valid_out_a", 32'(if_a.valid_out), 32'd0);
    check("rst_pc_src_a", 32'(if_a.pc_src), 32'd0);
    check("rst_flags_out", 32'(if_a.flags_out), 32'd0);
    reset = 1'b1;

    // EQ on cleared flags fails, so pcs must not reach pc_src
    drive(1, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0);  tick();
    // AL writes 0100 into bank0, then EQ passes and enables reg_write
    drive(1, 0, 0, 0, 4'b1110, 4'b0100, 2'b11, 0, 0, 0);  tick();
    drive(1, 0, 0, 0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0);  tick();
    drive(0, 0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0);  tick();
    check("bank0_after_write", 32'(m_flags[0]), 32'h4);
    // bank1 gets 1001; bank0 untouched; LT on bank1 fails since N==V
    drive(1, 0, 0, 1, 4'b1110, 4'b1001, 2'b11, 0, 0, 0);  tick();
    drive(0, 0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0);  tick();
    drive(1, 0, 0, 1, 4'b1011, 4'b0000, 2'b00, 1, 1, 1);  tick();
    // a valid instruction, then three stalled cycles: no flag write, outputs hold
    drive(1, 0, 0, 0, 4'b1110, 4'b0000, 2'b00, 1, 1, 0);  tick();
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 0, 0, 4'b1110, 4'b1111, 2'b11, 1, 1, 1);  tick();
    end
    // flush with stall clears outputs and blocks the flag write
    drive(1, 1, 1, 0, 4'b1110, 4'b1111, 2'b11, 0, 0, 1);  tick();
    drive(0, 0, 0, 0, 4'b1110, 4'b0000, 2'b00, 0, 0, 0);  tick();
    // out-of-range bank and NV never execute
    drive(1, 0, 0, 3, 4'b1110, 4'b1111, 2'b11, 1, 1, 1);  tick();
    drive(1, 0, 0, 1, 4'b1111, 4'b1111, 2'b11, 1, 1, 1);  tick();

    random_ticks(400);

    // reset asserted in the middle of a stall clears everything at once
    drive(1, 0, 0, 2, 4'b1110, 4'b1111, 2'b11, 1, 1, 1);  tick();
    drive(1, 1, 0, 2, 4'b1110, 4'b1111, 2'b11, 1, 1, 1);
    #2;
    reset = 1'b0;
    #1;
    model_clear();
    check("midrst_valid_out_a", 32'(if_a.valid_out), 32'd0);
    check("midrst_reg_write_a", 32'(if_a.reg_write), 32'd0);
    check("midrst_flags_out", 32'(if_a.flags_out), 32'd0);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 2, 4'b1110, 4'b0000, 2'b00, 0, 0, 0);  tick();

    random_ticks(200);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
